// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Used by hazard_stall_ctrl and anything that decodes its control bundle.
package pipeline_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_e;

    localparam logic [0:0] ST_RUN      = 1'(RUN);
    localparam logic [0:0] ST_MUL_WAIT = 1'(MUL_WAIT);

    // addi x0,x0,0 : what a bubble/flush loads into a pipeline register
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic pc_hold;
        logic ifid_hold;
        logic idex_hold;
        logic idex_bubble;
        logic exmem_bubble;
        logic ifid_flush;
        logic busy;
    } ctrl_t;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use stall, multi-cycle multiply freeze,
// taken-branch flush, and a saturating count of PC-hold cycles.
module hazard_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic                  id_is_mul_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_memread_i,
    input  logic                  ex_branch_taken_i,
    input  logic                  stat_clr_i,
    output logic                  pc_nen_write_o,
    output logic                  ifid_nen_write_o,
    output logic                  idex_nen_write_o,
    output logic                  idex_bubble_o,
    output logic                  exmem_bubble_o,
    output logic                  ifid_flush_o,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      stall_count_o
);

    logic [0:0] state_q, state_d;
    logic [2:0] mul_cnt_q, mul_cnt_d;
    logic       load_use;
    ctrl_t      ctrl, ctrl_g;

    // Each term is AND-qualified so don't-care register fields cannot leak through.
    assign load_use = ex_memread_i
                    & (ex_rd_i != REG_ADDR_W'(REG_ZERO))
                    & ((ex_rd_i == id_rs_i) | (id_uses_rt_i & (ex_rd_i == id_rt_i)));

    always_comb begin
        ctrl      = '0;
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (ex_branch_taken_i) begin
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_bubble = 1'b1;
                end else if (load_use) begin
                    ctrl.pc_hold     = 1'b1;
                    ctrl.ifid_hold   = 1'b1;
                    ctrl.idex_bubble = 1'b1;
                end else if (id_is_mul_i && (MUL_CYCLES > 1)) begin
                    // The multiply advances into EX this edge; freeze starts next cycle.
                    state_d   = ST_MUL_WAIT;
                    mul_cnt_d = 3'(MUL_CYCLES - 1);
                end
            end
            ST_MUL_WAIT: begin
                ctrl.pc_hold      = 1'b1;
                ctrl.ifid_hold    = 1'b1;
                ctrl.idex_hold    = 1'b1;
                ctrl.exmem_bubble = 1'b1;
                ctrl.busy         = 1'b1;
                if (mul_cnt_q <= 3'd1) begin
                    state_d   = ST_RUN;
                    mul_cnt_d = 3'd0;
                end else begin
                    mul_cnt_d = mul_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d   = ST_RUN;
                mul_cnt_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_RUN;
            mul_cnt_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Outputs are decoded from live inputs, so gate them while reset is held.
    assign ctrl_g = rst_ni ? ctrl : '0;

    assign pc_nen_write_o   = ctrl_g.pc_hold;
    assign ifid_nen_write_o = ctrl_g.ifid_hold;
    assign idex_nen_write_o = ctrl_g.idex_hold;
    assign idex_bubble_o    = ctrl_g.idex_bubble;
    assign exmem_bubble_o   = ctrl_g.exmem_bubble;
    assign ifid_flush_o     = ctrl_g.ifid_flush;
    assign busy_o           = ctrl_g.busy;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (ctrl_g.pc_hold),
        .clr_i  (stat_clr_i),
        .cnt_o  (stall_count_o)
    );

endmodule
